// File: rtl/filter_switch_ctrl.sv
// Filter band selector with programmable thresholds and per-boundary hysteresis.
// Every relay change runs blank -> switch -> settle with the DAC path muted.
// Force mode overrides automatic band selection.
module filter_switch_ctrl #(
    parameter int unsigned FW_WIDTH      = 32,
    parameter int unsigned NUM_BANDS     = 8,
    parameter int unsigned SEL_WIDTH     = 3,
    parameter int unsigned HYST          = 100000,
    parameter int unsigned BREAK_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter bit          INVERT_SEL    = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [FW_WIDTH-1:0]  FREQW,
    input  logic                 THR_WE,
    input  logic [SEL_WIDTH-1:0] THR_ADDR,
    input  logic [FW_WIDTH-1:0]  THR_DATA,
    input  logic                 FORCE_EN,
    input  logic [SEL_WIDTH-1:0] FORCE_ID,
    output logic [SEL_WIDTH-1:0] FILTER_ID,
    output logic [SEL_WIDTH-1:0] FILTER_SELECT,
    output logic                 MUTE,
    output logic                 BUSY,
    output logic                 SWITCH_DONE
);

    localparam int unsigned NumThr = NUM_BANDS - 1;
    localparam int unsigned MaxCnt = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [FW_WIDTH-1:0]  Step    = FW_WIDTH'((64'd1 << FW_WIDTH) / 64'(NUM_BANDS));
    localparam logic [FW_WIDTH:0]    HystExt = (FW_WIDTH + 1)'(HYST);
    localparam logic [SEL_WIDTH-1:0] TopBand = SEL_WIDTH'(NUM_BANDS - 1);
    localparam logic [SEL_WIDTH-1:0] TopThr  = SEL_WIDTH'(NumThr - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StSwitch, StSettle} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [FW_WIDTH-1:0]   thr_q [NumThr];
    logic [FW_WIDTH-1:0]   freqw_q;
    logic [SEL_WIDTH-1:0]  id_q, id_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [SEL_WIDTH-1:0]  tgt_q, tgt_d;
    logic                  done_q, done_d;
    // Distinguishes a settle that follows a real switch from the power-up settle.
    logic                  from_sw_q, from_sw_d;

    logic [SEL_WIDTH-1:0]  raw;
    logic [SEL_WIDTH-1:0]  up_idx, dn_idx;
    logic [FW_WIDTH:0]     up_sum;
    logic [FW_WIDTH-1:0]   up_lim, dn_lim;
    logic [SEL_WIDTH-1:0]  cand;

    function automatic logic [SEL_WIDTH-1:0] sel_code(input logic [SEL_WIDTH-1:0] id);
        return INVERT_SEL ? (TopBand - id) : id;
    endfunction

    // Threshold table: defaults at reset, writable in any state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NumThr); i++) begin
                thr_q[i] <= FW_WIDTH'(64'(i + 1) * 64'(Step));
            end
        end else if (THR_WE && (THR_ADDR < SEL_WIDTH'(NumThr))) begin
            thr_q[THR_ADDR] <= THR_DATA;
        end
    end

    // Raw band is a count of crossed thresholds, so any threshold order is defined.
    always_comb begin
        raw = '0;
        for (int i = 0; i < int'(NumThr); i++) begin
            if (freqw_q >= thr_q[i]) raw = raw + SEL_WIDTH'(1);
        end
    end

    // Candidate band with saturating hysteresis limits around the current band.
    always_comb begin
        up_idx = (id_q > TopThr) ? TopThr : id_q;
        dn_idx = (id_q == '0) ? '0 : id_q - SEL_WIDTH'(1);
        up_sum = {1'b0, thr_q[up_idx]} + HystExt;
        up_lim = up_sum[FW_WIDTH] ? '1 : up_sum[FW_WIDTH-1:0];
        dn_lim = ({1'b0, thr_q[dn_idx]} < HystExt) ? '0
                                                   : thr_q[dn_idx] - HystExt[FW_WIDTH-1:0];
        cand   = id_q;
        if (FORCE_EN) begin
            cand = (FORCE_ID > TopBand) ? TopBand : FORCE_ID;
        end else if ((raw > id_q) && (freqw_q >= up_lim)) begin
            cand = raw;
        end else if ((raw < id_q) && (freqw_q < dn_lim)) begin
            cand = raw;
        end
    end

    // Switch sequencer next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        id_d      = id_q;
        sel_d     = sel_q;
        from_sw_d = from_sw_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cand != id_q) begin
                    state_d = StBlank;
                    tgt_d   = cand;
                    cnt_d   = CntW'(BREAK_CYCLES - 1);
                end
            end
            StBlank: begin
                if (cnt_q == '0) state_d = StSwitch;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StSwitch: begin
                id_d      = tgt_q;
                sel_d     = sel_code(tgt_q);
                from_sw_d = 1'b1;
                state_d   = StSettle;
                cnt_d     = CntW'(SETTLE_CYCLES - 1);
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d   = StIdle;
                    done_d    = from_sw_q;
                    from_sw_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StSettle;
        endcase
    end

    // State and output registers; reset starts a muted settle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StSettle;
            cnt_q     <= CntW'(SETTLE_CYCLES - 1);
            freqw_q   <= '0;
            id_q      <= '0;
            sel_q     <= sel_code('0);
            tgt_q     <= '0;
            done_q    <= 1'b0;
            from_sw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            freqw_q   <= FREQW;
            id_q      <= id_d;
            sel_q     <= sel_d;
            tgt_q     <= tgt_d;
            done_q    <= done_d;
            from_sw_q <= from_sw_d;
        end
    end

    assign FILTER_ID     = id_q;
    assign FILTER_SELECT = sel_q;
    assign MUTE          = (state_q != StIdle);
    assign BUSY          = (state_q != StIdle);
    assign SWITCH_DONE   = done_q;

endmodule

// File: tb/tb_filter_switch_ctrl.sv
// Self-checking bench for filter_switch_ctrl: directed scenarios plus randomized
// frequency steps checked against a band-selection model.
module tb_filter_switch_ctrl;

    localparam longint HYST = 100000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] FREQW = '0;
    logic        THR_WE = 1'b0;
    logic [2:0]  THR_ADDR = '0;
    logic [31:0] THR_DATA = '0;
    logic        FORCE_EN = 1'b0;
    logic [2:0]  FORCE_ID = '0;
    logic [2:0]  FILTER_ID, FILTER_SELECT;
    logic        MUTE, BUSY, SWITCH_DONE;
    logic [2:0]  id6, sel6;
    logic        mute6, busy6, done6;

    int checks = 0;
    int failures = 0;
    int cur_m = 0;
    logic [31:0] thr_m [7];
    logic [31:0] prog_thr [7] = '{26396153, 40712710, 63977116, 101558080,
                                  171351299, 289462899, 523449139};
    logic [31:0] hyst_f [4] = '{64000000, 64100000, 63900000, 63800000};
    int          hyst_e [4] = '{2, 3, 3, 2};

    filter_switch_ctrl dut (
        .CLK(CLK), .RST(RST), .FREQW(FREQW), .THR_WE(THR_WE), .THR_ADDR(THR_ADDR),
        .THR_DATA(THR_DATA), .FORCE_EN(FORCE_EN), .FORCE_ID(FORCE_ID),
        .FILTER_ID(FILTER_ID), .FILTER_SELECT(FILTER_SELECT), .MUTE(MUTE), .BUSY(BUSY),
        .SWITCH_DONE(SWITCH_DONE)
    );

    filter_switch_ctrl #(.NUM_BANDS(6)) dut6 (
        .CLK(CLK), .RST(RST), .FREQW(FREQW), .THR_WE(1'b0), .THR_ADDR(3'd0),
        .THR_DATA(32'd0), .FORCE_EN(FORCE_EN), .FORCE_ID(FORCE_ID),
        .FILTER_ID(id6), .FILTER_SELECT(sel6), .MUTE(mute6), .BUSY(busy6),
        .SWITCH_DONE(done6)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_default_thr();
        for (int i = 0; i < 7; i++) thr_m[i] = 32'((i + 1) * 536870912);
    endtask

    // Band the selector should settle on, from the threshold/hysteresis rules.
    function automatic int model_band(int cur, logic [31:0] f, bit fen, int fid);
        int raw = 0;
        longint fl = longint'({32'd0, f});
        longint lim;
        if (fen) return (fid > 7) ? 7 : fid;
        for (int i = 0; i < 7; i++) if (f >= thr_m[i]) raw++;
        if (raw > cur) begin
            lim = longint'({32'd0, thr_m[cur]}) + HYST;
            if (lim > 64'hFFFF_FFFF) lim = 64'hFFFF_FFFF;
            return (fl >= lim) ? raw : cur;
        end
        if (raw < cur) begin
            lim = longint'({32'd0, thr_m[cur-1]}) - HYST;
            if (lim < 0) lim = 0;
            return (fl < lim) ? raw : cur;
        end
        return cur;
    endfunction

    // Follows a muted window, called on a sample where MUTE is already high.
    task automatic track(input int inj_at, input logic [31:0] inj_f, output int len,
                         output int dones, output int busy_bad, output logic [2:0] id_sw,
                         output logic [2:0] id_post, output logic done_end);
        len = 1;
        dones = int'(SWITCH_DONE);
        busy_bad = int'(BUSY !== MUTE);
        id_sw = '0;
        id_post = '0;
        while (MUTE === 1'b1 && len < 200) begin
            step();
            if (len == inj_at) FREQW = inj_f;
            busy_bad += int'(BUSY !== MUTE);
            if (MUTE === 1'b1) begin
                len++;
                dones += int'(SWITCH_DONE);
                if (len == 5) id_sw = FILTER_ID;
                if (len == 6) id_post = FILTER_ID;
            end
        end
        done_end = SWITCH_DONE;
    endtask

    int len, dones, busy_bad;
    logic [2:0] id_sw, id_post;
    logic done_end;
    logic [31:0] got_t, exp_t;

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        checks++;
        got_t = {24'd0, FILTER_ID, FILTER_SELECT, MUTE, BUSY};
        exp_t = {24'd0, 3'd0, 3'd7, 1'b1, 1'b1};
        if (got_t !== exp_t || SWITCH_DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals got=%0h exp=%0h done=%b", got_t, exp_t, SWITCH_DONE);
        end
        RST = 1'b0;
        track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
        checks++;
        got_t = {8'(len), 8'(dones), 8'(busy_bad), 7'd0, done_end};
        exp_t = {8'd16, 8'd0, 8'd0, 8'd0};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL reset_settle len/dones/busy/done got=%0h exp=%0h", got_t, exp_t);
        end
        cur_m = 0;
        set_default_thr();
    endtask

    task automatic test_program();
        for (int i = 0; i < 7; i++) begin
            THR_WE = 1'b1;
            THR_ADDR = 3'(i);
            THR_DATA = prog_thr[i];
            thr_m[i] = prog_thr[i];
            step();
        end
        THR_WE = 1'b0;
        FREQW = 50000000;
        step();
        checks++;
        if (MUTE !== 1'b0) begin
            failures++;
            $display("FAIL prog_latency_early got=%b exp=0", MUTE);
        end
        step();
        checks++;
        if (MUTE !== 1'b1) begin
            failures++;
            $display("FAIL prog_latency got=%b exp=1", MUTE);
        end
        track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
        checks++;
        got_t = {8'(len), 8'(dones), 8'(busy_bad), 7'd0, done_end};
        exp_t = {8'd21, 8'd0, 8'd0, 8'd1};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL prog_timing got=%0h exp=%0h", got_t, exp_t);
        end
        checks++;
        got_t = {20'd0, id_sw, id_post, FILTER_ID, FILTER_SELECT};
        exp_t = {20'd0, 3'd0, 3'd2, 3'd2, 3'd5};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL prog_band got=%0h exp=%0h", got_t, exp_t);
        end
        step();
        checks++;
        if ({SWITCH_DONE, MUTE} !== 2'b00) begin
            failures++;
            $display("FAIL prog_pulse_width got=%b exp=00", {SWITCH_DONE, MUTE});
        end
        cur_m = 2;
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) begin
            FREQW = hyst_f[i];
            step();
            step();
            if (hyst_e[i] != cur_m) begin
                track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
                checks++;
                got_t = {8'(len), 8'(dones), 8'(busy_bad), 7'd0, done_end};
                exp_t = {8'd21, 8'd0, 8'd0, 8'd1};
                if (got_t !== exp_t) begin
                    failures++;
                    $display("FAIL hyst_timing[%0d] got=%0h exp=%0h", i, got_t, exp_t);
                end
            end
            step();
            checks++;
            got_t = {28'd0, MUTE, FILTER_ID};
            exp_t = {28'd0, 1'b0, 3'(hyst_e[i])};
            if (got_t !== exp_t) begin
                failures++;
                $display("FAIL hyst_band[%0d] got=%0h exp=%0h", i, got_t, exp_t);
            end
            cur_m = hyst_e[i];
        end
    endtask

    task automatic test_overlap();
        FREQW = 600000000;
        step();
        step();
        track(10, 30000000, len, dones, busy_bad, id_sw, id_post, done_end);
        checks++;
        got_t = {8'(len), 8'(dones), 8'(busy_bad), 7'd0, done_end};
        exp_t = {8'd21, 8'd0, 8'd0, 8'd1};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL overlap_timing1 got=%0h exp=%0h", got_t, exp_t);
        end
        checks++;
        got_t = {20'd0, id_sw, id_post, FILTER_ID, FILTER_SELECT};
        exp_t = {20'd0, 3'd2, 3'd7, 3'd7, 3'd0};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL overlap_band1 got=%0h exp=%0h", got_t, exp_t);
        end
        step();
        checks++;
        if (MUTE !== 1'b1) begin
            failures++;
            $display("FAIL overlap_reenter got=%b exp=1", MUTE);
        end
        track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
        checks++;
        got_t = {8'(len), 8'(dones), 8'(busy_bad), 4'd0, id_post, done_end};
        exp_t = {8'd21, 8'd0, 8'd0, 4'd0, 3'd1, 1'b1};
        if (got_t !== exp_t || FILTER_SELECT !== 3'd6) begin
            failures++;
            $display("FAIL overlap_second got=%0h exp=%0h sel=%0d", got_t, exp_t, FILTER_SELECT);
        end
        cur_m = 1;
    endtask

    task automatic test_force();
        int fid [3] = '{6, 7, 0};
        bit fen [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            int e;
            FORCE_EN = fen[i];
            FORCE_ID = 3'(fid[i]);
            FREQW = 0;
            e = model_band(cur_m, 0, fen[i], fid[i]);
            step();
            checks++;
            if (MUTE !== 1'b1) begin
                failures++;
                $display("FAIL force_latency[%0d] got=%b exp=1", i, MUTE);
            end
            track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
            checks++;
            got_t = {8'(len), 8'(busy_bad), 1'b0, done_end, id_sw, id_post, FILTER_ID, FILTER_SELECT};
            exp_t = {8'd21, 8'd0, 1'b0, 1'b1, 3'(cur_m), 3'(e), 3'(e), 3'(7 - e)};
            if (got_t !== exp_t) begin
                failures++;
                $display("FAIL force_main[%0d] got=%0h exp=%0h", i, got_t, exp_t);
            end
            checks++;
            got_t = {23'd0, id6, sel6, busy6, mute6, done6};
            exp_t = (i < 2) ? {23'd0, 3'd5, 3'd0, 3'b000} : {23'd0, 3'd0, 3'd5, 3'b001};
            if (i == 0) exp_t[0] = 1'b1;
            if (got_t !== exp_t) begin
                failures++;
                $display("FAIL force_six_band[%0d] got=%0h exp=%0h", i, got_t, exp_t);
            end
            cur_m = e;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [31:0] f;
            int e;
            if ($urandom_range(0, 3) == 0) begin
                f = $urandom_range(0, 700000000);
            end else begin
                f = thr_m[$urandom_range(0, 6)] + 32'($urandom_range(0, 600000)) - 32'd300000;
            end
            e = model_band(cur_m, f, 1'b0, 0);
            FREQW = f;
            step();
            step();
            checks++;
            if (MUTE !== 1'(e != cur_m)) begin
                failures++;
                $display("FAIL rand_start[%0d] f=%0d got=%b exp=%b", n, f, MUTE, e != cur_m);
            end
            if (MUTE === 1'b1) begin
                track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
                checks++;
                got_t = {8'(len), 8'(dones), 8'(busy_bad), 7'd0, done_end};
                exp_t = {8'd21, 8'd0, 8'd0, 8'd1};
                if (got_t !== exp_t) begin
                    failures++;
                    $display("FAIL rand_timing[%0d] got=%0h exp=%0h", n, got_t, exp_t);
                end
            end else begin
                step();
                step();
            end
            checks++;
            got_t = {25'd0, MUTE, FILTER_ID, FILTER_SELECT};
            exp_t = {25'd0, 1'b0, 3'(e), 3'(7 - e)};
            if (got_t !== exp_t) begin
                failures++;
                $display("FAIL rand_band[%0d] f=%0d got=%0h exp=%0h", n, f, got_t, exp_t);
            end
            cur_m = e;
        end
    endtask

    task automatic test_reset_mid_blank();
        int e;
        FREQW = 64100000;
        e = model_band(cur_m, FREQW, 1'b0, 0);
        step();
        step();
        if (MUTE === 1'b1) track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
        checks++;
        if (FILTER_ID !== 3'(e)) begin
            failures++;
            $display("FAIL rmb_setup got=%0d exp=%0d", FILTER_ID, e);
        end
        FREQW = 600000000;
        step();
        step();
        step();
        RST = 1'b1;
        FREQW = 0;
        step();
        checks++;
        got_t = {24'd0, FILTER_ID, FILTER_SELECT, MUTE, BUSY};
        exp_t = {24'd0, 3'd0, 3'd7, 1'b1, 1'b1};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL rmb_reset got=%0h exp=%0h", got_t, exp_t);
        end
        RST = 1'b0;
        track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
        checks++;
        got_t = {8'(len), 8'(dones), 8'(busy_bad), 7'd0, done_end};
        exp_t = {8'd16, 8'd0, 8'd0, 8'd0};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL rmb_settle got=%0h exp=%0h", got_t, exp_t);
        end
        set_default_thr();
        cur_m = 0;
        FREQW = 600000000;
        e = model_band(cur_m, FREQW, 1'b0, 0);
        step();
        step();
        track(-1, 0, len, dones, busy_bad, id_sw, id_post, done_end);
        checks++;
        got_t = {8'(len), 12'd0, FILTER_ID, FILTER_SELECT, 3'd0, done_end};
        exp_t = {8'd21, 12'd0, 3'(e), 3'(7 - e), 3'd0, 1'b1};
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL rmb_default_thr got=%0h exp=%0h", got_t, exp_t);
        end
    endtask

    initial begin
        set_default_thr();
        test_reset();
        test_program();
        test_hysteresis();
        test_overlap();
        test_force();
        test_random();
        test_reset_mid_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_switch_ctrl.md
Name: filter_switch_ctrl

Overview:
Registered, parametrised successor to the combinational RF filter selector. It maps the DDS frequency word FREQW onto one of NUM_BANDS output filter bands using run-time programmable thresholds and per-boundary hysteresis. It sequences each relay change as blank → switch → settle, and mutes the DAC path for the duration. A manual force mode overrides automatic selection. It sits between the DDS frequency-word register and the filter-bank relay drivers and output mute.

Parameters:
FW_WIDTH, 32, frequency word / threshold width
NUM_BANDS, 8, number of filter bands (2..2^SEL_WIDTH)
SEL_WIDTH, 3, band index width
HYST, 100000, hysteresis in FREQW LSBs applied at every boundary
BREAK_CYCLES, 4, mute-before-switch cycles (>=1)
SETTLE_CYCLES, 16, mute-after-switch cycles (>=1)
INVERT_SEL, 1, 1: FILTER_SELECT = NUM_BANDS-1-FILTER_ID; 0: FILTER_SELECT = FILTER_ID

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
FREQW  in  FW_WIDTH  frequency word
THR_WE  in  1  threshold write strobe
THR_ADDR  in  SEL_WIDTH  threshold index, 0..NUM_BANDS-2
THR_DATA  in  FW_WIDTH  threshold value
FORCE_EN  in  1  manual band mode
FORCE_ID  in  SEL_WIDTH  manual band index
FILTER_ID  out  SEL_WIDTH  current band
FILTER_SELECT  out  SEL_WIDTH  relay code
MUTE  out  1  DAC mute
BUSY  out  1  high in any state other than IDLE
SWITCH_DONE  out  1  one-cycle pulse on return to IDLE after a switch

Behaviour:
- Single clock domain. Reset is synchronous and active-high; ports are named CLK and RST.
- Reset values:
  - FILTER_ID=0; FILTER_SELECT=NUM_BANDS-1 (INVERT_SEL=1) or 0.
  - MUTE=1, BUSY=1, SWITCH_DONE=0.
  - State=SETTLE with counter loaded, so power-up is muted for SETTLE_CYCLES.
  - THR[i]=(i+1)*floor(2^FW_WIDTH/NUM_BANDS).
  - FREQW_q=0.
- Threshold writes:
  - THR[THR_ADDR]<=THR_DATA on any cycle THR_WE=1, in any state.
  - THR_ADDR>=NUM_BANDS-1 is ignored.
  - The new value is used from the next cycle.
- Input register: FREQW_q<=FREQW every cycle.
- Raw band: raw = number of i with FREQW_q >= THR[i]. This is a count, so non-monotonic thresholds still yield a defined result.
- Candidate (automatic mode), with cur = FILTER_ID:
  - raw>cur: accepted only if FREQW_q >= sat_add(THR[cur], HYST). sat_add saturates to all-ones.
  - raw<cur: accepted only if FREQW_q < sat_sub(THR[cur-1], HYST). sat_sub saturates to 0.
  - Otherwise there is no change.
  - Multi-band jumps go directly to raw in a single switch.
- Force mode: FORCE_EN=1 makes the candidate min(FORCE_ID, NUM_BANDS-1). Hysteresis is bypassed.
- FSM IDLE → BLANK → SWITCH → SETTLE → IDLE:
  - IDLE: MUTE=0. If candidate≠cur, go to BLANK and latch the candidate into tgt.
  - BLANK: MUTE=1 for exactly BREAK_CYCLES cycles. FILTER_ID is unchanged.
  - SWITCH: one cycle; FILTER_ID<=tgt and FILTER_SELECT is updated in the same edge. MUTE=1.
  - SETTLE: MUTE=1 for exactly SETTLE_CYCLES cycles, then go to IDLE. SWITCH_DONE=1 in the first IDLE cycle. SWITCH_DONE is not pulsed after the reset-initiated settle.
- Latency: FREQW presented before edge k is latched at edge k, and BLANK is entered at edge k+1. The first muted cycle is therefore 2 cycles after the FREQW change. Total mute per switch = BREAK_CYCLES+1+SETTLE_CYCLES cycles.
- Changes during BLANK/SWITCH/SETTLE:
  - FREQW, FORCE and threshold changes do not alter tgt.
  - Re-evaluation happens in the first IDLE cycle. A pending difference re-enters BLANK on the next edge, and SWITCH_DONE still pulses for that IDLE cycle.
- Reset asserted in any state returns to reset values on the next edge and aborts any switch in progress.
- FILTER_SELECT is always registered and glitch-free; it changes only in SWITCH or at reset.

Test Plan:
- Reset: hold RST 2 cycles, release → FILTER_ID=0, FILTER_SELECT=7, MUTE=1 for 16 cycles then 0, BUSY falls with MUTE, no SWITCH_DONE.
- Program THR[0..6]=26396153, 40712710, 63977116, 101558080, 171351299, 289462899, 523449139; FREQW=50000000 → BLANK 2 cycles later, MUTE high 21 cycles, FILTER_ID=2, FILTER_SELECT=5, one SWITCH_DONE pulse.
- Hysteresis from band 2:
  - FREQW=64000000 → no switch.
  - FREQW=64100000 → FILTER_ID=3.
  - FREQW=63900000 → stays 3.
  - FREQW=63800000 → FILTER_ID=2.
- Jump and overlap: from band 2, FREQW=600000000 → single switch to 7 (FILTER_SELECT=0). During SETTLE set FREQW=30000000 → no change until IDLE, SWITCH_DONE pulses, then a second sequence ends at FILTER_ID=1.
- Force: FORCE_EN=1, FORCE_ID=6 with FREQW=0 → FILTER_ID=6. With NUM_BANDS=6 build, FORCE_ID=7 → FILTER_ID=5. FORCE_EN=0 → returns to raw band by hysteresis rules.
- Reset mid-BLANK (cycle 2 of 4) → next edge FILTER_ID=0, MUTE=1, state SETTLE; THR reverts to defaults (THR[0]=536870912 for 8 bands).
